// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with direct and auto-scan modes; all outputs one cycle after inputs.
// Optional sticky out-of-range flag `err` enabled by defining DECODER_SEQ_ERR_EN.
module decoder_seq #(
  parameter int SEL_W     = 5,
  parameter int OUT_N     = 32,
  parameter bit MASK_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             load,
  input  logic             step,
  output logic [OUT_N-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap
`ifdef DECODER_SEQ_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_e;

  localparam logic [SEL_W:0]   LIMIT = (SEL_W+1)'(OUT_N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_N - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             wrap_q, wrap_d;
  logic             sel_ok;
`ifdef DECODER_SEQ_ERR_EN
  logic             err_q, err_d;
`endif

  assign sel_ok = ({1'b0, sel_in} < LIMIT);

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    idx_d   = '0;
    hit_d   = 1'b0;
    wrap_d  = 1'b0;
`ifdef DECODER_SEQ_ERR_EN
    err_d   = err_q;
`endif
    if (enable) state_d = mode ? ST_SCAN : ST_DIRECT;

    case (state_d)
      ST_DIRECT: begin
        idx_d = sel_in;
        hit_d = sel_ok;
`ifdef DECODER_SEQ_ERR_EN
        if (!sel_ok) err_d = 1'b1;
`endif
      end
      ST_SCAN: begin
        if (load) begin
          cnt_d = sel_ok ? sel_in : '0;
`ifdef DECODER_SEQ_ERR_EN
          err_d = !sel_ok;
`endif
        end else if (step) begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Outputs follow the counter value this edge produces, not the old one.
        idx_d = cnt_d;
        hit_d = 1'b1;
      end
      default: ;
    endcase

    if (MASK_ZERO && idx_d == '0) hit_d = 1'b0;
    if (!hit_d) idx_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DECODER_SEQ_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign err = err_q;
`endif

  assign out_valid = hit_q && (state_q != ST_IDLE);
  assign cur_sel   = idx_q;
  assign wrap      = wrap_q;

  always_comb begin
    out = '0;
    for (int i = 0; i < OUT_N; i++) out[i] = out_valid && (cur_sel == SEL_W'(i));
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench: two decoder_seq instances (OUT_N=20 masked, OUT_N=32 unmasked) against an arithmetic reference model.
module tb_decoder_seq;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        mode    = 1'b0;
  logic [4:0]  sel_in  = '0;
  logic        load    = 1'b0;
  logic        step    = 1'b0;

  logic [19:0] out_a;
  logic [31:0] out_b;
  logic        vld_a, vld_b, wrap_a, wrap_b;
  logic [4:0]  cur_a, cur_b;
`ifdef DECODER_SEQ_ERR_EN
  logic        err_a, err_b;
`endif

  decoder_seq #(.SEL_W(5), .OUT_N(20), .MASK_ZERO(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .sel_in(sel_in),
    .load(load), .step(step), .out(out_a), .out_valid(vld_a), .cur_sel(cur_a), .wrap(wrap_a)
`ifdef DECODER_SEQ_ERR_EN
    , .err(err_a)
`endif
  );

  decoder_seq #(.SEL_W(5), .OUT_N(32), .MASK_ZERO(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .sel_in(sel_in),
    .load(load), .step(step), .out(out_b), .out_valid(vld_b), .cur_sel(cur_b), .wrap(wrap_b)
`ifdef DECODER_SEQ_ERR_EN
    , .err(err_b)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: index 0 = dut_a, index 1 = dut_b.
  int          nn [2] = '{20, 32};
  bit          mz [2] = '{1'b1, 1'b0};
  int          m_cnt [2];
  bit          m_err [2];
  logic [31:0] e_out [2];
  bit          e_vld [2];
  int          e_sel [2];
  bit          e_wrap [2];

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_err[k] = 0; e_out[k] = '0;
      e_vld[k] = 0; e_sel[k] = 0; e_wrap[k] = 0;
    end
  endtask

  task automatic model_edge(input bit en, input bit md, input int sel, input bit ld, input bit st);
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = -1;
      e_wrap[k] = 0;
      if (en && !md) begin
        if (sel < nn[k]) idx = sel;
        else m_err[k] = 1;
      end else if (en && md) begin
        if (ld) begin
          if (sel < nn[k]) begin m_cnt[k] = sel; m_err[k] = 0; end
          else begin m_cnt[k] = 0; m_err[k] = 1; end
        end else if (st) begin
          e_wrap[k] = (m_cnt[k] == nn[k] - 1);
          m_cnt[k]  = (m_cnt[k] + 1) % nn[k];
        end
        idx = m_cnt[k];
      end
      if (idx == 0 && mz[k]) idx = -1;
      e_vld[k] = (idx >= 0);
      e_out[k] = e_vld[k] ? (32'd1 << idx) : 32'd0;
      e_sel[k] = e_vld[k] ? idx : 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "out_a",  {12'd0, out_a},  e_out[0]);
    chk(tag, "vld_a",  32'(vld_a),      32'(e_vld[0]));
    chk(tag, "sel_a",  32'(cur_a),      32'(e_sel[0]));
    chk(tag, "wrap_a", 32'(wrap_a),     32'(e_wrap[0]));
    chk(tag, "out_b",  out_b,           e_out[1]);
    chk(tag, "vld_b",  32'(vld_b),      32'(e_vld[1]));
    chk(tag, "sel_b",  32'(cur_b),      32'(e_sel[1]));
    chk(tag, "wrap_b", 32'(wrap_b),     32'(e_wrap[1]));
    chk(tag, "hot_a",  32'($countones(out_a) <= 1), 32'd1);
`ifdef DECODER_SEQ_ERR_EN
    chk(tag, "err_a",  32'(err_a),      32'(m_err[0]));
    chk(tag, "err_b",  32'(err_b),      32'(m_err[1]));
`endif
  endtask

  task automatic cyc(input string tag, input bit en, input bit md, input int sel, input bit ld, input bit st);
    enable = en; mode = md; sel_in = 5'(sel); load = ld; step = st;
    model_edge(en, md, sel, ld, st);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    cyc("tp1_dir5", 1, 0, 5, 0, 0);
    chk("tp1_dir5", "const_out_b", out_b, 32'h0000_0020);
    cyc("tp1_off", 0, 0, 5, 0, 0);
    chk("tp1_off", "const_vld_b", 32'(vld_b), 32'd0);

    cyc("tp2_dir0", 1, 0, 0, 0, 0);
    chk("tp2_dir0", "const_out_b", out_b, 32'h1);
    chk("tp2_dir0", "const_out_a", {12'd0, out_a}, 32'h0);

    cyc("tp3_dir25", 1, 0, 25, 0, 0);
    cyc("tp3_dir3", 1, 0, 3, 0, 0);
    cyc("tp3_load3", 1, 1, 3, 1, 0);
    cyc("tp3_load25", 1, 1, 25, 1, 0);
    cyc("tp3_step_ld", 1, 1, 3, 1, 1);

    cyc("tp4_load18", 1, 1, 18, 1, 0);
    cyc("tp4_step19", 1, 1, 0, 0, 1);
    cyc("tp4_wrap", 1, 1, 0, 0, 1);
    chk("tp4_wrap", "const_wrap_a", 32'(wrap_a), 32'd1);
    cyc("tp4_step1", 1, 1, 0, 0, 1);
    chk("tp4_step1", "const_out_a", {12'd0, out_a}, 32'h2);

    cyc("tp5_ldstep7", 1, 1, 7, 1, 1);
    cyc("tp5_dir2", 1, 0, 2, 1, 1);
    cyc("tp5_step8", 1, 1, 0, 0, 1);
    chk("tp5_step8", "const_out_b", out_b, 32'h100);
    cyc("tp5_hold", 1, 1, 9, 0, 0);
    cyc("tp5_idle", 0, 1, 9, 1, 1);
    cyc("tp5_resume", 1, 1, 9, 0, 1);

    cyc("tp6_load10", 1, 1, 10, 1, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("tp6_async");
    #1;
    reset_n = 1'b1;
    cyc("tp6_step1", 1, 1, 0, 0, 1);
    chk("tp6_step1", "const_out_a", {12'd0, out_a}, 32'h2);

    cyc("b_load31", 1, 1, 31, 1, 0);
    cyc("b_wrap", 1, 1, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      bit en, md, ld, st;
      int sel;
      en  = ($urandom_range(0, 7) != 0);
      md  = (i < 150) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 5) != 0);
      sel = $urandom_range(0, 31);
      ld  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 3) != 0);
      cyc("rand", en, md, sel, ld, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
